// File: rtl/airi5c_gpio_irq_pkg.sv
// Shared definitions for the AIRI5C GPIO port with interrupts.
// Holds the HASTI bus widths, the register offsets within the GPIO window,
// and the encodings used by the IMODE and IPOL registers.
package airi5c_gpio_irq_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY = '0;

  // Byte offsets of the ten registers relative to BASE_ADDR.
  typedef enum logic [5:0] {
    GPIO_DOUT  = 6'h00,
    GPIO_DEN   = 6'h04,
    GPIO_DIN   = 6'h08,
    GPIO_DSET  = 6'h0C,
    GPIO_DCLR  = 6'h10,
    GPIO_DTGL  = 6'h14,
    GPIO_IEN   = 6'h18,
    GPIO_IMODE = 6'h1C,
    GPIO_IPOL  = 6'h20,
    GPIO_IPEND = 6'h24
  } gpio_off_e;

  typedef enum logic {
    IMODE_LEVEL = 1'b0,
    IMODE_EDGE  = 1'b1
  } gpio_imode_e;

  typedef enum logic {
    IPOL_LOW  = 1'b0,
    IPOL_HIGH = 1'b1
  } gpio_ipol_e;

endpackage

// File: rtl/airi5c_gpio_irq_if.sv
// HASTI (AHB-lite) bus bundle between a master and the GPIO slave.
// master drives the request (haddr .. hwdata); slave returns hrdata,
// hready and hresp.
interface airi5c_gpio_irq_if import airi5c_gpio_irq_pkg::*; ();

  logic [HASTI_ADDR_WIDTH-1:0]  haddr;
  logic                         hwrite;
  logic [HASTI_SIZE_WIDTH-1:0]  hsize;
  logic [HASTI_BURST_WIDTH-1:0] hburst;
  logic                         hmastlock;
  logic [HASTI_PROT_WIDTH-1:0]  hprot;
  logic [HASTI_TRANS_WIDTH-1:0] htrans;
  logic [HASTI_BUS_WIDTH-1:0]   hwdata;
  logic [HASTI_BUS_WIDTH-1:0]   hrdata;
  logic                         hready;
  logic [HASTI_RESP_WIDTH-1:0]  hresp;

  modport master (
    output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/airi5c_gpio_irq_sync.sv
// airi5c_sync: plain flop chain used to bring asynchronous signals into the
// clk domain. Shared with other peripherals.
// Ports: clk, nreset (sync, active-low), d (async in), q (synchronized out).
module airi5c_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/airi5c_gpio_irq.sv
// airi5c_gpio_irq: parametrised GPIO port on the HASTI bus with atomic
// set/clear/toggle of outputs and per-pin level/edge interrupts.
// Ports:
//   clk, nreset  single clock, synchronous active-low reset
//   bus          HASTI slave (zero wait states, always OKAY)
//   gpio_d       output data register
//   gpio_en      output enable, 1 = drive
//   gpio_i       asynchronous pin inputs
//   irq          registered level-high interrupt, |(IPEND & IEN)
module airi5c_gpio_irq import airi5c_gpio_irq_pkg::*; #(
  parameter logic [31:0] BASE_ADDR   = 32'hC0000008,
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nreset,
  airi5c_gpio_irq_if.slave bus,
  output logic [WIDTH-1:0] gpio_d,
  output logic [WIDTH-1:0] gpio_en,
  input  logic [WIDTH-1:0] gpio_i,
  output logic             irq
);

  function automatic logic [31:0] widen(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic             valid_r;
  logic             hwrite_r;
  logic [31:0]      haddr_r;

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] din_prev;
  logic [WIDTH-1:0] ien;
  logic [WIDTH-1:0] imode;
  logic [WIDTH-1:0] ipol;
  logic [WIDTH-1:0] ipend;
  logic [WIDTH-1:0] ipend_nxt;

  logic [31:0]      off;
  logic             hit;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] lvl_hit;
  logic [31:0]      rdata;

  airi5c_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (gpio_i),
    .q      (din)
  );

  // Sub-word accesses are treated as full words, so the byte lane bits are
  // dropped before decoding. The base is word- but not 64-byte-aligned,
  // hence the subtraction rather than a bit-field compare.
  assign off   = {haddr_r[31:2], 2'b00} - BASE_ADDR;
  assign hit   = (off[31:6] == 26'd0);
  assign wr    = valid_r & hwrite_r & hit;
  assign rd    = valid_r & ~hwrite_r & hit;
  assign wdata = bus.hwdata[WIDTH-1:0];

  assign rise     = din & ~din_prev;
  assign fall     = ~din & din_prev;
  assign edge_hit = ien & ((ipol & rise) | (~ipol & fall));
  assign lvl_hit  = ien & ~(din ^ ipol);
  assign w1c      = (wr && off[5:0] == GPIO_IPEND) ? wdata : '0;

  // Edge-mode bits hold until cleared, with a new edge beating a same-cycle
  // W1C; level-mode bits simply follow the pin and ignore W1C.
  always_comb begin
    ipend_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (imode[i] == IMODE_EDGE)
        ipend_nxt[i] = edge_hit[i] | (ipend[i] & ~w1c[i]);
      else
        ipend_nxt[i] = lvl_hit[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      valid_r  <= 1'b0;
      hwrite_r <= 1'b0;
      haddr_r  <= '0;
      din_prev <= '0;
      gpio_d   <= '0;
      gpio_en  <= '0;
      ien      <= '0;
      imode    <= '0;
      ipol     <= '0;
      ipend    <= '0;
      irq      <= 1'b0;
    end else begin
      // address phase -> data phase
      valid_r <= bus.htrans[1];
      if (bus.htrans[1]) begin
        haddr_r  <= bus.haddr;
        hwrite_r <= bus.hwrite;
      end
      din_prev <= din;
      ipend    <= ipend_nxt;
      irq      <= |(ipend & ien);
      // data phase write commit
      if (wr) begin
        case (off[5:0])
          GPIO_DOUT:  gpio_d  <= wdata;
          GPIO_DEN:   gpio_en <= wdata;
          GPIO_DSET:  gpio_d  <= gpio_d | wdata;
          GPIO_DCLR:  gpio_d  <= gpio_d & ~wdata;
          GPIO_DTGL:  gpio_d  <= gpio_d ^ wdata;
          GPIO_IEN:   ien     <= wdata;
          GPIO_IMODE: imode   <= wdata;
          GPIO_IPOL:  ipol    <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off[5:0])
        GPIO_DOUT:  rdata = widen(gpio_d);
        GPIO_DEN:   rdata = widen(gpio_en);
        GPIO_DIN:   rdata = widen(din);
        GPIO_IEN:   rdata = widen(ien);
        GPIO_IMODE: rdata = widen(imode);
        GPIO_IPOL:  rdata = widen(ipol);
        GPIO_IPEND: rdata = widen(ipend);
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.hrdata = rdata;
  assign bus.hready = 1'b1;
  assign bus.hresp  = HASTI_RESP_OKAY;

  logic unused_bus;
  assign unused_bus = ^{bus.hsize, bus.hburst, bus.hmastlock, bus.hprot,
                        bus.htrans[0], bus.hwdata, haddr_r[1:0], off[1:0]};

endmodule
